ips2l_pcie_dma_tx_cpld_gen: RTL and testbench

- Downstream of the DMA RX top. Consumes the memory-read request it decodes (mrd tc/attr/length/id/tag/addr plus valid/ready), reads the payload from the BAR0 RAM read port, and emits one CplD TLP per request on the 128-bit AXIS slave (TX) interface of the PCIe core.
- Drives the RX side's tx-ready input, so the RX side only offers a new request when this block is idle.

---
 rtl/ips2l_pcie_dma_tx_cpld_gen_if.sv | 29 ++
 rtl/ips2l_pcie_dma_tx_cpld_gen.sv | 182 ++++++++++++++++++
 tb/tb_ips2l_pcie_dma_tx_cpld_gen.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ips2l_pcie_dma_tx_cpld_gen_if.sv
// Request + AXIS TX bundle for the CplD generator.
// master = generator side, slave = RX decoder / PCIe core side.
interface ips2l_pcie_dma_tx_cpld_gen_if;
    logic [2:0]   mrd_tc;
    logic [2:0]   mrd_attr;
    logic [9:0]   mrd_length;
    logic [15:0]  mrd_id;
    logic [7:0]   mrd_tag;
    logic [63:0]  mrd_addr;
    logic         cpld_req_vld;
    logic         cpld_req_rdy;
    logic         cpld_tx_rdy;
    logic         axis_slave_tvld;
    logic         axis_slave_trdy;
    logic [127:0] axis_slave_tdata;
    logic [3:0]   axis_slave_tkeep;
    logic         axis_slave_tlast;

    modport master (
        input  mrd_tc, mrd_attr, mrd_length, mrd_id, mrd_tag, mrd_addr, cpld_req_vld, axis_slave_trdy,
        output cpld_req_rdy, cpld_tx_rdy, axis_slave_tvld, axis_slave_tdata, axis_slave_tkeep,
               axis_slave_tlast
    );
    modport slave (
        output mrd_tc, mrd_attr, mrd_length, mrd_id, mrd_tag, mrd_addr, cpld_req_vld, axis_slave_trdy,
        input  cpld_req_rdy, cpld_tx_rdy, axis_slave_tvld, axis_slave_tdata, axis_slave_tkeep,
               axis_slave_tlast
    );
endinterface

// File: rtl/ips2l_pcie_dma_tx_cpld_gen.sv
// One CplD TLP per memory-read request, payload streamed from BAR0 RAM with DW realignment.
// Optional IPS2L_PCIE_DMA_CPLD_CNT_EN adds o_cpld_cnt (completed TLP count).
module ips2l_pcie_dma_tx_cpld_gen #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  i_cfg_cpl_id,
    ips2l_pcie_dma_tx_cpld_gen_if.master io_if,
    output logic                         o_bar0_rd_clk_en,
    output logic [ADDR_WIDTH-1:0]        o_bar0_rd_addr,
    input  logic [127:0]                 i_bar0_rd_data
`ifdef IPS2L_PCIE_DMA_CPLD_CNT_EN
    ,
    output logic [31:0]                  o_cpld_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HDR, DATA} state_t;

    state_t                r_state;
    logic                  r_req_rdy;
    logic [15:0]           r_cpl_id;
    logic [15:0]           r_id;
    logic [2:0]            r_tc;
    logic [2:0]            r_attr;
    logic [9:0]            r_len;
    logic [7:0]            r_tag;
    logic [4:0]            r_addr_dw;
    logic                  r_single;
    logic [1:0]            r_last_dw;
    logic [8:0]            r_beats_left;
    logic [8:0]            r_rd_left;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_pend;
    logic [1:0]            r_cnt;
    logic [2:0][127:0]     r_q;

    logic [10:0]  w_n;
    logic [10:0]  w_span;
    logic [10:0]  w_nplus2;
    logic         w_acc;
    logic         w_beat_rdy;
    logic         w_tvld;
    logic         w_hs;
    logic         w_last;
    logic         w_pop;
    logic [2:0]   w_occ;
    logic         w_rd_en;
    logic [2:0]   w_s;
    logic [255:0] w_pair;
    logic [31:0]  w_h0;
    logic [31:0]  w_h1;
    logic [31:0]  w_h2;
    logic [31:0]  w_p0;

    assign w_n      = (io_if.mrd_length == 10'd0) ? 11'd1024 : {1'b0, io_if.mrd_length};
    assign w_span   = w_n + {9'd0, io_if.mrd_addr[3:2]} - 11'd1;
    assign w_nplus2 = w_n + 11'd2;

    // Words are queued oldest-first; a data beat straddles q[0] and q[1].
    assign w_acc      = (r_state == IDLE) && io_if.cpld_req_vld && r_req_rdy;
    assign w_beat_rdy = (r_cnt >= 2'd2) || ((r_cnt != 2'd0) && (r_rd_left == 9'd0) && !r_pend);
    assign w_tvld     = (r_state == HDR) || ((r_state == DATA) && w_beat_rdy);
    assign w_hs       = w_tvld && io_if.axis_slave_trdy;
    assign w_last     = ((r_state == HDR) && r_single) || ((r_state == DATA) && (r_beats_left == 9'd1));
    assign w_pop      = w_hs && (r_state == DATA);
    // Read only when the returning word is guaranteed a free slot.
    assign w_occ      = {1'b0, r_cnt} + {2'b00, r_pend};
    assign w_rd_en    = (r_state != IDLE) && (r_rd_left != 9'd0) && (w_occ <= 3'd2 + {2'b00, w_pop});

    assign w_s    = {1'b0, r_addr_dw[1:0]} + 3'd1;
    assign w_pair = {r_q[1], r_q[0]};
    assign w_p0   = r_q[0][{r_addr_dw[1:0], 5'd0} +: 32];
    assign w_h0   = {3'b010, 5'b01010, 1'b0, r_tc, 1'b0, r_attr[2], 4'b0000, r_attr[1:0], 2'b00, r_len};
    assign w_h1   = {r_cpl_id, 4'b0000, r_len, 2'b00};
    assign w_h2   = {r_id, r_tag, 1'b0, r_addr_dw, 2'b00};

    assign io_if.cpld_req_rdy     = r_req_rdy;
    assign io_if.cpld_tx_rdy      = r_req_rdy;
    assign io_if.axis_slave_tvld  = w_tvld;
    assign io_if.axis_slave_tlast = w_last;
    assign io_if.axis_slave_tdata = (r_state == HDR)  ? {w_p0, w_h2, w_h1, w_h0} :
                                    (r_state == DATA) ? w_pair[{w_s, 5'd0} +: 128] : '0;
    assign io_if.axis_slave_tkeep = (r_state == HDR)  ? 4'b1111 :
                                    (r_state == DATA) ? (w_last ? (4'b1111 >> (2'd3 - r_last_dw)) : 4'b1111)
                                                      : 4'b0000;
    assign o_bar0_rd_clk_en = w_rd_en;
    assign o_bar0_rd_addr   = r_rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_rdy    <= 1'b1;
            r_cpl_id     <= '0;
            r_id         <= '0;
            r_tc         <= '0;
            r_attr       <= '0;
            r_len        <= '0;
            r_tag        <= '0;
            r_addr_dw    <= '0;
            r_single     <= 1'b0;
            r_last_dw    <= '0;
            r_beats_left <= '0;
            r_rd_left    <= '0;
            r_rd_addr    <= '0;
            r_pend       <= 1'b0;
            r_cnt        <= '0;
            r_q          <= '0;
        end else begin
            r_pend <= w_rd_en;
            if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_rd_left <= r_rd_left - 9'd1;
            end

            if (w_acc) begin
                r_cnt <= '0;
            end else begin
                case ({w_pop, r_pend})
                    2'b01: begin
                        r_q[r_cnt] <= i_bar0_rd_data;
                        r_cnt      <= r_cnt + 2'd1;
                    end
                    2'b10: begin
                        r_q[0] <= r_q[1];
                        r_q[1] <= r_q[2];
                        r_cnt  <= r_cnt - 2'd1;
                    end
                    2'b11: begin
                        r_q[0]             <= r_q[1];
                        r_q[1]             <= r_q[2];
                        r_q[r_cnt - 2'd1]  <= i_bar0_rd_data;
                    end
                    default: ;
                endcase
            end

            case (r_state)
                IDLE: if (w_acc) begin
                    r_state      <= FETCH;
                    r_req_rdy    <= 1'b0;
                    r_cpl_id     <= i_cfg_cpl_id;
                    r_id         <= io_if.mrd_id;
                    r_tc         <= io_if.mrd_tc;
                    r_attr       <= io_if.mrd_attr;
                    r_len        <= io_if.mrd_length;
                    r_tag        <= io_if.mrd_tag;
                    r_addr_dw    <= io_if.mrd_addr[6:2];
                    r_single     <= (w_n == 11'd1);
                    r_last_dw    <= w_n[1:0] + 2'd2;
                    r_beats_left <= w_nplus2[10:2];
                    r_rd_left    <= w_span[10:2] + 9'd1;
                    r_rd_addr    <= io_if.mrd_addr[ADDR_WIDTH+3:4];
                end
                FETCH: if (r_pend) r_state <= HDR;
                HDR: if (w_hs) begin
                    r_state   <= r_single ? IDLE : DATA;
                    r_req_rdy <= r_single;
                end
                DATA: if (w_hs) begin
                    r_beats_left <= r_beats_left - 9'd1;
                    if (w_last) begin
                        r_state   <= IDLE;
                        r_req_rdy <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef IPS2L_PCIE_DMA_CPLD_CNT_EN
    logic [31:0] r_cpld_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_cpld_cnt <= '0;
        else if (w_hs && w_last) r_cpld_cnt <= r_cpld_cnt + 32'd1;
    end
    assign o_cpld_cnt = r_cpld_cnt;
`endif

endmodule

// File: tb/tb_ips2l_pcie_dma_tx_cpld_gen.sv
// Scoreboard bench for the CplD generator: flat-DW reference model, random trdy, monitor on negedge.
module tb_ips2l_pcie_dma_tx_cpld_gen;
    localparam int AW = 9;
    typedef struct packed {logic [127:0] d; logic [3:0] k; logic l;} beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   cpl_id = 16'h0100;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [127:0]  rd_data = '0;
    logic [127:0]  ram [0:(1<<AW)-1];
    logic [31:0]   cpld_cnt;
    bit            rmode = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            busy = 0;
    int            ncpl = 0;
    beat_t         expq[$];

    ips2l_pcie_dma_tx_cpld_gen_if bus ();

    ips2l_pcie_dma_tx_cpld_gen #(.ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_cfg_cpl_id     (cpl_id),
        .io_if            (bus),
        .o_bar0_rd_clk_en (rd_en),
        .o_bar0_rd_addr   (rd_addr),
        .i_bar0_rd_data   (rd_data)
`ifdef IPS2L_PCIE_DMA_CPLD_CNT_EN
        ,
        .o_cpld_cnt       (cpld_cnt)
`endif
    );
`ifndef IPS2L_PCIE_DMA_CPLD_CNT_EN
    assign cpld_cnt = '0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    initial begin
        bus.axis_slave_trdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.axis_slave_trdy = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dw(input int idx);
        logic [127:0] w;
        w = ram[(idx >> 2) % (1 << AW)];
        return w[(idx % 4) * 32 +: 32];
    endfunction

    function automatic void push_model(input logic [9:0] len, input logic [63:0] addr, input logic [2:0] tc,
                                       input logic [2:0] attr, input logic [15:0] id, input logic [7:0] tag,
                                       input logic [15:0] cid);
        int n, base, nb;
        beat_t b;
        logic [31:0] h0, h1, h2;
        n    = (len == 10'd0) ? 1024 : int'(len);
        base = int'(addr[AW+3:4]) * 4 + int'(addr[3:2]);
        h0   = {3'b010, 5'b01010, 1'b0, tc, 1'b0, attr[2], 4'b0000, attr[1:0], 2'b00, len};
        h1   = {cid, 4'b0000, 12'(n * 4)};
        h2   = {id, tag, 1'b0, addr[6:2], 2'b00};
        b.d  = {dw(base), h2, h1, h0};
        b.k  = 4'hF;
        b.l  = (n == 1);
        expq.push_back(b);
        nb = 1 + (n + 2) / 4;
        for (int j = 1; j < nb; j++) begin
            b = '0;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = 4 * j - 3 + i;
                if (k < n) begin
                    b.d[i*32 +: 32] = dw(base + k);
                    b.k[i] = 1'b1;
                end
            end
            b.l = (j == nb - 1);
            expq.push_back(b);
        end
    endfunction

    // Call #1 after a posedge; returns #1 after the accepting edge with vld still high.
    task automatic send(input logic [9:0] len, input logic [63:0] addr, input logic [2:0] tc,
                        input logic [2:0] attr, input logic [15:0] id, input logic [7:0] tag,
                        input logic [15:0] cid, input bit use_model);
        int t;
        t = 0;
        cpl_id = cid;
        bus.mrd_length = len; bus.mrd_addr = addr; bus.mrd_tc = tc;
        bus.mrd_attr = attr; bus.mrd_id = id; bus.mrd_tag = tag;
        bus.cpld_req_vld = 1'b1;
        @(negedge clk);
        while (!bus.cpld_req_rdy && t < 5000) begin
            t++;
            @(negedge clk);
        end
        if (!bus.cpld_req_rdy) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout act=rdy0 exp=rdy1 t=%0t", $time);
        end else if (use_model) begin
            push_model(len, addr, tc, attr, id, tag, cid);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        bus.cpld_req_vld = 1'b0;
        while ((expq.size() != 0 || busy != 0) && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout act=%0d_pending exp=0 t=%0t", expq.size(), $time);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: handshakes are committed at the following posedge.
    bit    prev_stall = 0;
    bit    prev_hs_nl = 0;
    bit    seen_first = 0;
    int    lat = 0;
    beat_t prev_b;
    always @(negedge clk) begin
        beat_t cur, e;
        logic [127:0] m;
        cur = {bus.axis_slave_tdata, bus.axis_slave_tkeep, bus.axis_slave_tlast};
        if (!rst_n) begin
            busy = 0; ncpl = 0; prev_stall = 0; prev_hs_nl = 0; seen_first = 0;
        end else begin
            chk("req_rdy", bus.cpld_req_rdy, busy == 0);
            chk("tx_rdy", bus.cpld_tx_rdy, busy == 0);
            if (prev_stall) begin
                chk("stall_tvld", bus.axis_slave_tvld, 1'b1);
                chk("stall_hold", cur, prev_b);
            end
            if (prev_hs_nl && !rmode) chk("no_bubble", bus.axis_slave_tvld, 1'b1);
            if (busy != 0 && !seen_first) begin
                if (bus.axis_slave_tvld) begin
                    chk("latency_le4", lat <= 4, 1'b1);
                    seen_first = 1;
                end
                lat++;
            end
            prev_hs_nl = 0;
            if (bus.axis_slave_tvld && bus.axis_slave_trdy) begin
                if (expq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_beat act=%h exp=none", bus.axis_slave_tdata);
                end else begin
                    e = expq.pop_front();
                    for (int i = 0; i < 4; i++) m[i*32 +: 32] = {32{e.k[i]}};
                    chk("tdata", bus.axis_slave_tdata & m, e.d & m);
                    chk("tkeep", bus.axis_slave_tkeep, e.k);
                    chk("tlast", bus.axis_slave_tlast, e.l);
                end
                if (bus.axis_slave_tlast) begin
                    busy = 0; ncpl++;
                end else begin
                    prev_hs_nl = 1;
                end
            end
            prev_stall = bus.axis_slave_tvld && !bus.axis_slave_trdy;
            prev_b = cur;
            if (bus.cpld_req_vld && bus.cpld_req_rdy) begin
                busy = 1; lat = 0; seen_first = 0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        for (int i = 0; i < (1 << AW); i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
        ram[1][31:0] = 32'hDDDDDDDD;
        bus.cpld_req_vld = 1'b0;
        bus.mrd_length = '0; bus.mrd_addr = '0; bus.mrd_tc = '0;
        bus.mrd_attr = '0; bus.mrd_id = '0; bus.mrd_tag = '0;
        repeat (3) @(negedge clk);
        chk("rst_tvld", bus.axis_slave_tvld, 1'b0);
        chk("rst_tlast", bus.axis_slave_tlast, 1'b0);
        chk("rst_tkeep", bus.axis_slave_tkeep, 4'b0);
        chk("rst_tdata", bus.axis_slave_tdata, 128'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_rd_addr", rd_addr, '0);
        chk("rst_req_rdy", bus.cpld_req_rdy, 1'b1);
        chk("rst_tx_rdy", bus.cpld_tx_rdy, 1'b1);
`ifdef IPS2L_PCIE_DMA_CPLD_CNT_EN
        chk("rst_cnt", cpld_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single DW, literal expectation
        b.d = {32'hDDDDDDDD, 32'h00000510, 32'h01000004, 32'h4A000001};
        b.k = 4'hF; b.l = 1'b1;
        expq.push_back(b);
        send(10'd1, 64'h10, 3'd0, 3'd0, 16'h0000, 8'h05, 16'h0100, 1'b0);
        wait_idle();

        // 8 DW unaligned, then 1024 DW wrapping from word 511
        send(10'd8, 64'h08, 3'd5, 3'd6, 16'hBEEF, 8'h11, 16'h0100, 1'b1);
        wait_idle();
        send(10'd0, 64'h1FF0, 3'd7, 3'd7, 16'h1234, 8'hFF, 16'hA5A5, 1'b1);
        wait_idle();

        // same 8 DW request under random backpressure
        rmode = 1'b1;
        send(10'd8, 64'h08, 3'd5, 3'd6, 16'hBEEF, 8'h11, 16'h0100, 1'b1);
        wait_idle();
        rmode = 1'b0;

        // back-to-back with vld held
        send(10'd9, 64'h2C, 3'd1, 3'd2, 16'h0042, 8'h21, 16'h0200, 1'b1);
        send(10'd3, 64'h34, 3'd2, 3'd1, 16'h0043, 8'h22, 16'h0200, 1'b1);
        wait_idle();

        // reset during beat 2 of a 5-beat TLP
        send(10'd17, 64'h40, 3'd0, 3'd0, 16'h0007, 8'h33, 16'h0100, 1'b1);
        bus.cpld_req_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk("mid_rst_tvld", bus.axis_slave_tvld, 1'b0);
        chk("mid_rst_rdy", bus.cpld_req_rdy, 1'b1);
        chk("mid_rst_tx_rdy", bus.cpld_tx_rdy, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(10'd17, 64'h40, 3'd0, 3'd0, 16'h0007, 8'h33, 16'h0100, 1'b1);
        wait_idle();

        // randomized requests
        for (int r = 0; r < 40; r++) begin
            logic [9:0] len;
            int gap;
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
                rmode = 1'($urandom_range(0, 1));
            end
            len = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(1, 40));
            send(len, {$urandom, $urandom}, 3'($urandom), 3'($urandom), 16'($urandom), 8'($urandom),
                 16'($urandom), 1'b1);
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                bus.cpld_req_vld = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        chk("queue_empty", expq.size(), 0);
`ifdef IPS2L_PCIE_DMA_CPLD_CNT_EN
        chk("cpld_cnt", cpld_cnt, ncpl);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
